display_scan_controller: RTL and testbench

Time-multiplexes one shared number-to-digit converter across the three clock fields (seconds, minutes, hours), driving a 6-digit common-anode 7-segment display one digit at a time. It snapshots field values on a load strobe and commits them only at frame boundaries, so no frame shows a mix of old and new values. It inserts an anti-ghosting blank at the start of each digit slot and supports per-field blinking for time-set mode. It sits between the timekeeping counters and the display pins, and owns the converter's number input.

---
 rtl/display_scan_controller_pkg.sv | 23 ++
 rtl/display_scan_controller_scan_timer.sv | 54 +++++
 rtl/display_scan_controller.sv | 139 +++++++++++++
 tb/tb_display_scan_controller.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/display_scan_controller_pkg.sv
// Shared constants and types for the multiplexed 6-digit clock display.
package display_scan_controller_pkg;

    localparam logic [2:0] DIG_SEC_LO = 3'd0;
    localparam logic [2:0] DIG_SEC_HI = 3'd1;
    localparam logic [2:0] DIG_MIN_LO = 3'd2;
    localparam logic [2:0] DIG_MIN_HI = 3'd3;
    localparam logic [2:0] DIG_HR_LO  = 3'd4;
    localparam logic [2:0] DIG_HR_HI  = 3'd5;

    localparam logic [5:0] AN_OFF = 6'b111111;

    typedef enum logic {
        BLANK = 1'b0,
        SHOW  = 1'b1
    } scan_state_t;

    // Active-low enable pattern with only the selected digit driven.
    function automatic logic [5:0] digit_mask(input logic [2:0] digit);
        return AN_OFF & ~(6'd1 << digit);
    endfunction

endpackage

// File: rtl/display_scan_controller_scan_timer.sv
// Slot/digit sequencing for the display scan, plus frame counting for blink.
module scan_timer
    import display_scan_controller_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLINK_FRAMES = 64,
    parameter int SLOT_W       = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic [SLOT_W-1:0] slot_cnt,
    output logic [2:0]        digit,
    output logic              slot_last,
    output logic              frame_done,
    output logic              blink_phase
);

    localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FRAME_W-1:0] frame_cnt;

    assign slot_last = (slot_cnt == SLOT_W'(SCAN_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt    <= '0;
            digit       <= DIG_SEC_LO;
            frame_done  <= 1'b0;
            frame_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (slot_last) begin
                slot_cnt <= '0;
                if (digit == DIG_HR_HI) begin
                    // frame_done rises together with digit returning to 0
                    digit      <= DIG_SEC_LO;
                    frame_done <= 1'b1;
                    if (frame_cnt == FRAME_W'(BLINK_FRAMES - 1)) begin
                        frame_cnt   <= '0;
                        blink_phase <= ~blink_phase;
                    end else begin
                        frame_cnt <= frame_cnt + 1'b1;
                    end
                end else begin
                    digit <= digit + 3'd1;
                end
            end else begin
                slot_cnt <= slot_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/display_scan_controller.sv
// Drives a 6-digit common-anode display from seconds/minutes/hours through one
// shared number-to-digit converter, with tear-free loads, ghost blanking and blink.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int BLINK_FRAMES = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] seconds,
    input  logic [5:0] minutes,
    input  logic [5:0] hours,
    input  logic       load,
    input  logic [2:0] blink_en,
    output logic [5:0] conv_number,
    input  logic [7:0] conv_low,
    input  logic [7:0] conv_high,
    output logic [7:0] seg,
    output logic [5:0] an,
    output logic       frame_done
);

    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

    logic [SLOT_W-1:0] slot_cnt;
    logic [2:0]        digit;
    logic              slot_last;
    logic              blink_phase;

    logic [5:0]  stage_sec, stage_min, stage_hr;
    logic [5:0]  shadow_sec, shadow_min, shadow_hr;
    logic        load_pending;
    scan_state_t state;
    logic [5:0]  an_show;
    logic        blink_sel;

    scan_timer #(
        .SCAN_DIV    (SCAN_DIV),
        .BLINK_FRAMES(BLINK_FRAMES),
        .SLOT_W      (SLOT_W)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .slot_cnt   (slot_cnt),
        .digit      (digit),
        .slot_last  (slot_last),
        .frame_done (frame_done),
        .blink_phase(blink_phase)
    );

    always_comb begin
        conv_number = shadow_hr;
        blink_sel   = blink_en[2];
        case (digit[2:1])
            2'd0: begin
                conv_number = shadow_sec;
                blink_sel   = blink_en[0];
            end
            2'd1: begin
                conv_number = shadow_min;
                blink_sel   = blink_en[1];
            end
            default: begin
                conv_number = shadow_hr;
                blink_sel   = blink_en[2];
            end
        endcase
    end

    // Shadows only change on the frame_done cycle, so every frame is built from one snapshot.
    always_ff @(posedge clk) begin
        if (rst) begin
            stage_sec    <= '0;
            stage_min    <= '0;
            stage_hr     <= '0;
            shadow_sec   <= '0;
            shadow_min   <= '0;
            shadow_hr    <= '0;
            load_pending <= 1'b0;
        end else if (frame_done) begin
            if (load) begin
                shadow_sec <= seconds;
                shadow_min <= minutes;
                shadow_hr  <= hours;
            end else if (load_pending) begin
                shadow_sec <= stage_sec;
                shadow_min <= stage_min;
                shadow_hr  <= stage_hr;
            end
            load_pending <= 1'b0;
        end else if (load) begin
            stage_sec    <= seconds;
            stage_min    <= minutes;
            stage_hr     <= hours;
            load_pending <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            seg <= 8'h00;
        end else begin
            seg <= digit[0] ? conv_high : conv_low;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= BLANK;
            an_show <= AN_OFF;
        end else begin
            case (state)
                BLANK: begin
                    an_show <= AN_OFF;
                    if (slot_cnt == SLOT_W'(BLANK_CYCLES - 1)) begin
                        state   <= SHOW;
                        an_show <= digit_mask(digit);
                    end
                end
                SHOW: begin
                    if (slot_last) begin
                        state   <= BLANK;
                        an_show <= AN_OFF;
                    end
                end
                default: begin
                    state   <= BLANK;
                    an_show <= AN_OFF;
                end
            endcase
        end
    end

    // Blink masks combinationally so a blink_en change darkens the digit immediately.
    assign an = an_show | {6{blink_phase & blink_sel}};

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with a small decimal converter model.
module tb_display_scan_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [5:0] seconds = '0;
    logic [5:0] minutes = '0;
    logic [5:0] hours = '0;
    logic       load = 1'b0;
    logic [2:0] blink_en = '0;
    logic [5:0] conv_number;
    logic [7:0] conv_low;
    logic [7:0] conv_high;
    logic [7:0] seg;
    logic [5:0] an;
    logic       frame_done;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    assign conv_low  = {2'b00, conv_number % 6'd10};
    assign conv_high = {2'b00, conv_number / 6'd10};

    display_scan_controller #(
        .SCAN_DIV    (8),
        .BLANK_CYCLES(2),
        .BLINK_FRAMES(2)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .seconds    (seconds),
        .minutes    (minutes),
        .hours      (hours),
        .load       (load),
        .blink_en   (blink_en),
        .conv_number(conv_number),
        .conv_low   (conv_low),
        .conv_high  (conv_high),
        .seg        (seg),
        .an         (an),
        .frame_done (frame_done)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Entered at slot 0 of digit k, leaves at slot 0 of the next digit.
    task automatic check_digit(input string pfx, input int k, input logic [7:0] exp_seg,
                               input bit dark, input bit exp_fd, input bit do_load);
        logic [5:0] exp_an;
        exp_an = dark ? 6'h3F : ~(6'd1 << k);
        chk($sformatf("%s_d%0d_fd", pfx, k), {31'd0, frame_done}, {31'd0, exp_fd});
        chk($sformatf("%s_d%0d_blank0", pfx, k), {26'd0, an}, 32'h3F);
        if (do_load) load = 1'b1;
        tick(1);
        load = 1'b0;
        chk($sformatf("%s_d%0d_blank1", pfx, k), {26'd0, an}, 32'h3F);
        tick(1);
        chk($sformatf("%s_d%0d_an", pfx, k), {26'd0, an}, {26'd0, exp_an});
        chk($sformatf("%s_d%0d_seg", pfx, k), {24'd0, seg}, {24'd0, exp_seg});
        tick(6);
    endtask

    task automatic check_frame(input string pfx, input logic [47:0] segs,
                               input logic [5:0] dark, input bit fd);
        for (int k = 0; k < 6; k++)
            check_digit(pfx, k, segs[8*k +: 8], dark[k], (k == 0) ? fd : 1'b0, 1'b0);
    endtask

    task automatic wait_fd();
        int n;
        n = 0;
        while (frame_done !== 1'b1 && n < 100) begin
            tick(1);
            n++;
        end
        chk("fd_wait", {31'd0, frame_done}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        // Reset held for three cycles
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_an", {26'd0, an}, 32'h3F);
        chk("rst_seg", {24'd0, seg}, 32'h00);
        chk("rst_conv", {26'd0, conv_number}, 32'd0);
        chk("rst_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Scan order: 42 / 17 / 9
        seconds = 6'd42; minutes = 6'd17; hours = 6'd9;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        wait_fd();
        check_frame("scan", 48'h00_09_01_07_04_02, 6'b000000, 1'b1);

        // Tear-free load of 59 at digit 2
        check_digit("tf", 0, 8'h02, 1'b0, 1'b1, 1'b0);
        check_digit("tf", 1, 8'h04, 1'b0, 1'b0, 1'b0);
        seconds = 6'd59;
        check_digit("tf", 2, 8'h07, 1'b0, 1'b0, 1'b1);
        check_digit("tf", 3, 8'h01, 1'b0, 1'b0, 1'b0);
        check_digit("tf", 4, 8'h09, 1'b0, 1'b0, 1'b0);
        check_digit("tf", 5, 8'h00, 1'b0, 1'b0, 1'b0);
        check_frame("tfnext", 48'h00_09_01_07_05_09, 6'b000000, 1'b1);

        // Load of 30 on the frame_done cycle shows in the same frame
        seconds = 6'd30;
        check_digit("bd", 0, 8'h00, 1'b0, 1'b1, 1'b1);
        check_digit("bd", 1, 8'h03, 1'b0, 1'b0, 1'b0);
        check_digit("bd", 2, 8'h07, 1'b0, 1'b0, 1'b0);
        check_digit("bd", 3, 8'h01, 1'b0, 1'b0, 1'b0);
        check_digit("bd", 4, 8'h09, 1'b0, 1'b0, 1'b0);
        check_digit("bd", 5, 8'h00, 1'b0, 1'b0, 1'b0);

        // Mid-frame reset with a staged load pending
        check_digit("mr", 0, 8'h00, 1'b0, 1'b1, 1'b0);
        check_digit("mr", 1, 8'h03, 1'b0, 1'b0, 1'b0);
        check_digit("mr", 2, 8'h07, 1'b0, 1'b0, 1'b0);
        check_digit("mr", 3, 8'h01, 1'b0, 1'b0, 1'b0);
        chk("mr_d4_blank0", {26'd0, an}, 32'h3F);
        seconds = 6'd55;
        load = 1'b1;
        tick(1);
        load = 1'b0;
        rst = 1'b1;
        tick(1);
        chk("mr_an", {26'd0, an}, 32'h3F);
        chk("mr_seg", {24'd0, seg}, 32'h00);
        chk("mr_conv", {26'd0, conv_number}, 32'd0);
        chk("mr_fd", {31'd0, frame_done}, 32'd0);
        rst = 1'b0;

        // Blink minutes: dark in frames 2 and 3 only; staged 55 never appears
        blink_en = 3'b010;
        check_frame("bl0", 48'h0, 6'b000000, 1'b0);
        check_frame("bl1", 48'h0, 6'b000000, 1'b1);
        check_frame("bl2", 48'h0, 6'b001100, 1'b1);
        check_frame("bl3", 48'h0, 6'b001100, 1'b1);
        check_frame("bl4", 48'h0, 6'b000000, 1'b1);
        check_frame("bl5", 48'h0, 6'b000000, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
